// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-file geometry and index type
// reused by decode, writeback and the register file.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/cpu_register_file_if.sv
// Decode-stage register read/reserve port: decode is master, register file
// is slave.
interface cpu_register_file_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] reg_s;
  logic [ADDR_W-1:0] reg_t;
  logic [DATA_W-1:0] reg_s_data;
  logic [DATA_W-1:0] reg_t_data;
  logic              reg_stall;
  logic              reserve_valid;
  logic [ADDR_W-1:0] reg_id_d;

  modport master (
    output reg_s, reg_t, reserve_valid, reg_id_d,
    input  reg_s_data, reg_t_data, reg_stall
  );

  modport slave (
    input  reg_s, reg_t, reserve_valid, reg_id_d,
    output reg_s_data, reg_t_data, reg_stall
  );

endinterface

// File: rtl/cpu_scoreboard.sv
// Outstanding-write scoreboard: per-register pending counters, operand
// readiness, reservation stall and the sticky unreserved-writeback flag.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reg_s,
  input  logic [ADDR_W-1:0] reg_t,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reg_id_d,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic              flush,
  output logic              reg_stall,
  output logic              wb_error
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [NREG-1:0][PEND_W-1:0] pend;
  logic [NREG-1:0]             inc_v;
  logic [NREG-1:0]             dec_v;
  logic                        rdy_s;
  logic                        rdy_t;
  logic                        full_d;
  logic                        reserve_ok;

  always_comb begin
    rdy_s = (reg_s == ZERO) || (pend[reg_s] == '0) ||
            ((pend[reg_s] == PEND_W'(1)) && wb_valid && (wb_reg == reg_s));
    rdy_t = (reg_t == ZERO) || (pend[reg_t] == '0) ||
            ((pend[reg_t] == PEND_W'(1)) && wb_valid && (wb_reg == reg_t));
    // A saturated counter can still take a reservation when a writeback to
    // the same register frees a slot in the same cycle.
    full_d = reserve_valid && (reg_id_d != ZERO) && (pend[reg_id_d] == '1) &&
             !(wb_valid && (wb_reg == reg_id_d));
    reg_stall  = !rdy_s || !rdy_t || full_d;
    reserve_ok = reserve_valid && !reg_stall && (reg_id_d != ZERO);
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      inc_v[i] = reserve_ok && (reg_id_d == ADDR_W'(i));
      dec_v[i] = wb_valid && (wb_reg == ADDR_W'(i));
    end
  end

  // r0 can never be reserved, so its counter stays 0 through the same path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      wb_error <= 1'b0;
    end else if (flush) begin
      pend <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (inc_v[i] && !dec_v[i])
          pend[i] <= pend[i] + PEND_W'(1);
        else if (!inc_v[i] && dec_v[i] && (pend[i] != '0))
          pend[i] <= pend[i] - PEND_W'(1);
      end
      if (wb_valid && (wb_reg != ZERO) && (pend[wb_reg] == '0))
        wb_error <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_register_file.sv
// Architectural register file: storage, same-cycle writeback bypass and the
// r0-reads-zero rule, with write tracking delegated to cpu_scoreboard.
module cpu_register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  cpu_register_file_if.slave  dec,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                flush,
  output logic                wb_error
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]           s_data;
  logic [DATA_W-1:0]           t_data;
  logic                        stall;

  // Flush only clears reservations; writeback data is always committed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      regs <= '0;
    else if (wb_valid && (wb_reg != ZERO))
      regs[wb_reg] <= wb_data;
  end

  always_comb begin
    if (dec.reg_s == ZERO)
      s_data = '0;
    else if (wb_valid && (wb_reg == dec.reg_s))
      s_data = wb_data;
    else
      s_data = regs[dec.reg_s];

    if (dec.reg_t == ZERO)
      t_data = '0;
    else if (wb_valid && (wb_reg == dec.reg_t))
      t_data = wb_data;
    else
      t_data = regs[dec.reg_t];
  end

  assign dec.reg_s_data = s_data;
  assign dec.reg_t_data = t_data;
  assign dec.reg_stall  = stall;

  cpu_scoreboard #(
    .ADDR_W (ADDR_W),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .reg_s         (dec.reg_s),
    .reg_t         (dec.reg_t),
    .reserve_valid (dec.reserve_valid),
    .reg_id_d      (dec.reg_id_d),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .reg_stall     (stall),
    .wb_error      (wb_error)
  );

endmodule

// File: tb/tb_cpu_register_file.sv
// Directed bench for cpu_register_file: expected outputs are queued with each
// stimulus step and compared at the sample point.
module tb_cpu_register_file;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        wb_error;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [31:0] s;
    logic [31:0] t;
    logic        stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  cpu_register_file_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  cpu_register_file #(
    .DATA_W (32),
    .ADDR_W (5),
    .PEND_W (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dec      (dif.slave),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .flush    (flush),
    .wb_error (wb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input string tag,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic rv, input logic [4:0] d,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic fl,
                       input logic [31:0] es, input logic [31:0] et,
                       input logic est, input logic eer);
    exp_t e;
    dif.reg_s         = s;
    dif.reg_t         = t;
    dif.reserve_valid = rv;
    dif.reg_id_d      = d;
    wb_valid          = wv;
    wb_reg            = wr;
    wb_data           = wd;
    flush             = fl;
    e.tag   = tag;
    e.s     = es;
    e.t     = et;
    e.stall = est;
    e.err   = eer;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      assert (dif.reg_s_data === e.s) else begin
        miscompares++;
        $error("FAIL %s reg_s_data got %h want %h", e.tag, dif.reg_s_data, e.s);
      end
      vectors++;
      assert (dif.reg_t_data === e.t) else begin
        miscompares++;
        $error("FAIL %s reg_t_data got %h want %h", e.tag, dif.reg_t_data, e.t);
      end
      vectors++;
      assert (dif.reg_stall === e.stall) else begin
        miscompares++;
        $error("FAIL %s reg_stall got %b want %b", e.tag, dif.reg_stall, e.stall);
      end
      vectors++;
      assert (wb_error === e.err) else begin
        miscompares++;
        $error("FAIL %s wb_error got %b want %b", e.tag, wb_error, e.err);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;

    // reset state
    apply("rst",        0, 5, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    reset = 1'b1;

    // r0: writes ignored, never reserved, no wb_error
    apply("r0_wr_res",  0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    apply("r0_read",    0, 0, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();

    // r5: reserve, stall, bypassed writeback, stored read
    apply("r5_res",     0, 0, 1, 5, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    apply("r5_stall",   5, 0, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 1, 0); check();
    apply("r5_wb_byp",  5, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 32'h0, 0, 0); check();
    tick();
    apply("r5_read",    5, 5, 0, 0, 0, 0, 32'h0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0); check();

    // r3: reserve then same-cycle writeback releases stall
    apply("r3_res",     0, 0, 1, 3, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    apply("r3_stall",   3, 0, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 1, 0); check();
    apply("r3_wb_byp",  3, 0, 0, 0, 1, 3, 32'h0000_1234, 0,  32'h0000_1234, 32'h0, 0, 0); check();
    tick();
    apply("r3_read",    0, 3, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0000_1234, 0, 0); check();

    // r7: saturate counter at 3
    for (int i = 0; i < 3; i++) begin
      apply("r7_res",   0, 0, 1, 7, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
      tick();
    end
    apply("r7_full",    0, 0, 1, 7, 0, 0, 32'h0, 0,  32'h0, 32'h0, 1, 0); check();
    apply("r7_res_wb",  0, 0, 1, 7, 1, 7, 32'h0000_0077, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    apply("r7_wb1",     7, 0, 0, 0, 1, 7, 32'h0000_0071, 0,  32'h0000_0071, 32'h0, 1, 0); check();
    tick();
    apply("r7_wb2",     7, 0, 0, 0, 1, 7, 32'h0000_0072, 0,  32'h0000_0072, 32'h0, 1, 0); check();
    tick();
    apply("r7_wb3",     7, 0, 0, 0, 1, 7, 32'h0000_0073, 0,  32'h0000_0073, 32'h0, 0, 0); check();
    tick();
    apply("r7_idle",    7, 7, 0, 0, 0, 0, 32'h0, 0,  32'h0000_0073, 32'h0000_0073, 0, 0); check();

    // flush discards r4/r9 reservations; later r4 writeback is unreserved
    apply("r4_res",     0, 0, 1, 4, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    apply("r9_res",     0, 0, 1, 9, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    tick();
    apply("r4r9_stall", 4, 9, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 1, 0); check();
    apply("flush",      4, 9, 0, 0, 0, 0, 32'h0, 1,  32'h0, 32'h0, 1, 0); check();
    tick();
    apply("post_flush", 4, 9, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    apply("r4_wb_unres",4, 9, 0, 0, 1, 4, 32'h0000_ABCD, 0,  32'h0000_ABCD, 32'h0, 0, 0); check();
    tick();
    apply("wb_err",     4, 9, 0, 0, 0, 0, 32'h0, 0,  32'h0000_ABCD, 32'h0, 0, 1); check();

    // r2 reserved with data 0x55, then asynchronous reset
    apply("r2_res",     0, 0, 1, 2, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 1); check();
    tick();
    apply("r2_wb_res",  0, 0, 1, 2, 1, 2, 32'h0000_0055, 0,  32'h0, 32'h0, 0, 1); check();
    tick();
    apply("r2_held",    2, 4, 0, 0, 0, 0, 32'h0, 0,  32'h0000_0055, 32'h0000_ABCD, 1, 1); check();
    reset = 1'b0;
    apply("async_rst",  2, 4, 0, 0, 0, 0, 32'h0, 0,  32'h0, 32'h0, 0, 0); check();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_register_file.md
# cpu_register_file

Architectural register file plus write scoreboard for the MIPS pipeline. It is the responder to the instruction-decode stage's register read/reserve interface: it returns operand data for `reg_s`/`reg_t`, tracks outstanding writes to destinations reserved via `reg_id_d`, and raises `reg_stall` while a source operand is not yet written back. Writes arrive from the writeback stage; a flush port discards all reservations on pipeline redirect.

## Interface
Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 5: register index width; 2**ADDR_W registers.
- `PEND_W`, 2: per-register outstanding-write counter width.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `reg_s`  in  ADDR_W  source-1 index from decode.
- `reg_t`  in  ADDR_W  source-2 index from decode.
- `reg_s_data`  out  DATA_W  source-1 data.
- `reg_t_data`  out  DATA_W  source-2 data.
- `reg_stall`  out  1  operand(s) not ready, or reservation impossible.
- `reserve_valid`  in  1  decode issues an instruction writing `reg_id_d`.
- `reg_id_d`  in  ADDR_W  destination being reserved.
- `wb_valid`  in  1  writeback strobe.
- `wb_reg`  in  ADDR_W  writeback destination.
- `wb_data`  in  DATA_W  writeback value.
- `flush`  in  1  clear all reservations.
- `wb_error`  out  1  sticky: writeback to an unreserved register.

## Operation
- Storage: 2**ADDR_W × DATA_W registers; r0 reads 0 always, writes to r0 ignored, r0 never reserved.
- Reads are combinational. A read of index i returns `wb_data` when `wb_valid && wb_reg==i && i!=0` (same-cycle bypass); otherwise it returns the stored value.
- Scoreboard: each register i≠0 has an unsigned counter `pend[i]` of PEND_W bits.
- Per-cycle counter update, in priority order:
  - `flush`: all counters go to 0. A reservation in the same cycle is dropped. A writeback in the same cycle still writes data and does not set `wb_error`.
  - Otherwise, for each register, +1 if reserved this cycle (`reserve_valid && !reg_stall && reg_id_d==i`), −1 if written back this cycle.
  - Reserve and writeback to the same register in the same cycle leave the counter unchanged.
- A source port is ready when index==0, or `pend`==0, or (`pend`==1 and a same-cycle writeback hits it).
- `reg_stall` is asserted when:
  - `reg_s` is not ready, or `reg_t` is not ready, or
  - `reserve_valid && reg_id_d!=0 && pend[reg_id_d]` is at its maximum (2**PEND_W−1) and no same-cycle writeback hits `reg_id_d`.
- A reservation is accepted only when `reg_stall` is 0.
- A writeback to i with `pend[i]`==0 (and no flush): data is written, the counter stays 0 (no underflow), and `wb_error` is set until reset.

## Timing
- Reset values: all registers 0, all counters 0, `wb_error` 0. With reset asserted, `reg_s_data`/`reg_t_data` therefore read 0 and `reg_stall` is 0.
- Read latency is 0 cycles (combinational from indices and the writeback bus).
- Write latency: data written at posedge N is visible from storage in cycle N+1; via the bypass it is visible in cycle N itself.
- Reservation effect: accepted at posedge N, it stalls readers of that register from cycle N+1 onward.
- Reset asserted mid-operation clears storage and counters immediately (asynchronous). Writebacks in flight across reset are discarded.
- `reg_stall` depends on the request and writeback inputs combinationally, with no registered delay. The decode side must not drive `reg_s`/`reg_t`/`reg_id_d` combinationally from `reg_stall`.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `ADDR_W` defaults, `REG_ZERO` constant, and a `reg_idx_t` typedef reused by the decode and writeback stages.
- Sub-module `cpu_scoreboard`: counters, flush, ready/stall logic and `wb_error`. The top level holds storage, bypass muxes and the r0 rule.

## Test plan
- Reset, then read r0 and r5 → both data 0, `reg_stall`=0; write r5=0xDEADBEEF → next cycle `reg_s`=5 reads 0xDEADBEEF.
- Reserve r3, next cycle `reg_s`=3 → `reg_stall`=1. Writeback r3=0x1234 → `reg_stall`=0 in that same cycle and `reg_s_data`=0x1234 via bypass.
- Reserve r7 three times (PEND_W=2) → counter 3; a fourth reserve of r7 asserts `reg_stall`. Simultaneous reserve+writeback of r7 → counter stays 3 and the reserve is accepted.
- Reserve r4 and r9, then `flush` → next cycle reads of r4/r9 do not stall; a later writeback r4 sets `wb_error`=1 and writes the data.
- Write r0=0xFFFFFFFF and reserve r0 → r0 reads 0 and never stalls; `wb_error` stays 0.
- Drop `reset` with r2 reserved and r2=0x55 → r2 reads 0 and `reg_stall` deasserts immediately, without waiting for a clock edge.
